logic_basic_queue_arbiter: RTL and testbench

- Packet-aware arbiter that shares one AXI4-Stream output between INPUTS queue read-side streams.
- Each input is typically the tx side of a basic queue.
- Grants one input at a time and holds the grant until the beat with rx_tlast transfers.
- Output is a registered slice; the source index is reported on tx_tid.

---
 rtl/logic_basic_queue_arbiter_pkg.sv | 14 +
 rtl/logic_basic_queue_arbiter_select.sv | 39 +++
 rtl/logic_basic_queue_arbiter.sv | 147 ++++++++++++++
 tb/tb_logic_basic_queue_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_basic_queue_arbiter_pkg.sv
// Shared types and helpers for the packet-aware queue arbiter.
// Optional macro LOGIC_BASIC_QUEUE_ARBITER_FIXED_PRIORITY_EN is consumed by the top.
package logic_basic_queue_arbiter_pkg;

  typedef enum logic {
    FSM_IDLE   = 1'b0,
    FSM_LOCKED = 1'b1
  } fsm_e;

  function automatic int id_width(input int inputs);
    return ($clog2(inputs) > 0) ? $clog2(inputs) : 1;
  endfunction

endpackage

// File: rtl/logic_basic_queue_arbiter_select.sv
// Rotated priority encoder: first asserted request at or after pointer, wrapping to 0.
// The search is split into an upper pass (index >= pointer) and a lower pass (any index).
module logic_basic_queue_arbiter_select
  import logic_basic_queue_arbiter_pkg::*;
#(
  parameter int INPUTS   = 2,
  parameter int ID_WIDTH = id_width(INPUTS)
) (
  input  logic [INPUTS-1:0]   request,
  input  logic [ID_WIDTH-1:0] pointer,
  output logic [ID_WIDTH-1:0] index,
  output logic                found
);

  logic                hi_found;
  logic                lo_found;
  logic [ID_WIDTH-1:0] hi_index;
  logic [ID_WIDTH-1:0] lo_index;

  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_index = '0;
    lo_index = '0;
    for (int i = 0; i < INPUTS; i++) begin
      if (!hi_found && request[i] && (ID_WIDTH'(i) >= pointer)) begin
        hi_found = 1'b1;
        hi_index = ID_WIDTH'(i);
      end
      if (!lo_found && request[i]) begin
        lo_found = 1'b1;
        lo_index = ID_WIDTH'(i);
      end
    end
    found = hi_found || lo_found;
    index = hi_found ? hi_index : lo_index;
  end

endmodule

// File: rtl/logic_basic_queue_arbiter.sv
// Packet-aware arbiter sharing one registered AXI4-Stream slice between INPUTS sources.
// Define LOGIC_BASIC_QUEUE_ARBITER_FIXED_PRIORITY_EN for lowest-index-wins arbitration.
//
//   state      | meaning
//   FSM_IDLE   | no grant; searching rx_tvalid from the pointer, rx_tready all low
//   FSM_LOCKED | grant held until the granted input transfers its tlast beat
module logic_basic_queue_arbiter
  import logic_basic_queue_arbiter_pkg::*;
#(
  parameter  int INPUTS     = 2,
  parameter  int DATA_WIDTH = 1,
  localparam int ID_WIDTH   = id_width(INPUTS)
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [INPUTS-1:0]     rx_tvalid,
  output logic [INPUTS-1:0]     rx_tready,
  input  logic [INPUTS-1:0]     rx_tlast,
  input  logic [DATA_WIDTH-1:0] rx_tdata [INPUTS],
  input  logic                  tx_tready,
  output logic                  tx_tvalid,
  output logic                  tx_tlast,
  output logic [ID_WIDTH-1:0]   tx_tid,
  output logic [DATA_WIDTH-1:0] tx_tdata
);

  localparam logic [ID_WIDTH-1:0] LAST_IDX = ID_WIDTH'(INPUTS - 1);

  fsm_e                  state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_q, grant_d;
  logic [ID_WIDTH-1:0]   ptr;
  logic [ID_WIDTH-1:0]   sel_index;
  logic                  sel_found;
  logic                  g_valid, g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  slot_open;
  logic                  accept;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic [ID_WIDTH-1:0]   tid_q, tid_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;

`ifdef LOGIC_BASIC_QUEUE_ARBITER_FIXED_PRIORITY_EN
  assign ptr = '0;
`else
  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  assign ptr = ptr_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  logic_basic_queue_arbiter_select #(
    .INPUTS   (INPUTS),
    .ID_WIDTH (ID_WIDTH)
  ) u_select (
    .request (rx_tvalid),
    .pointer (ptr),
    .index   (sel_index),
    .found   (sel_found)
  );

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < INPUTS; i++) begin
      if (grant_q == ID_WIDTH'(i)) begin
        g_valid = rx_tvalid[i];
        g_last  = rx_tlast[i];
        g_data  = rx_tdata[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rx_tready = '0;
    accept    = 1'b0;
    slot_open = tx_tready || !tvalid_q;
    tvalid_d  = tvalid_q && !tx_tready;
    tlast_d   = tlast_q;
    tid_d     = tid_q;
    tdata_d   = tdata_q;
`ifndef LOGIC_BASIC_QUEUE_ARBITER_FIXED_PRIORITY_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      FSM_IDLE: begin
        if (sel_found) begin
          grant_d = sel_index;
          state_d = FSM_LOCKED;
        end
      end
      FSM_LOCKED: begin
        for (int i = 0; i < INPUTS; i++) begin
          rx_tready[i] = slot_open && (grant_q == ID_WIDTH'(i));
        end
        accept = g_valid && slot_open;
        if (accept) begin
          tvalid_d = 1'b1;
          tlast_d  = g_last;
          tid_d    = grant_q;
          tdata_d  = g_data;
          if (g_last) begin
            state_d = FSM_IDLE;
`ifndef LOGIC_BASIC_QUEUE_ARBITER_FIXED_PRIORITY_EN
            // explicit wrap so non-power-of-2 INPUTS rotates correctly
            ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + ID_WIDTH'(1);
`endif
          end
        end
      end
      default: state_d = FSM_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= FSM_IDLE;
      grant_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tid_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tid_q    <= tid_d;
    end
  end

  // data path is qualified by tx_tvalid, so it carries no reset
  always_ff @(posedge aclk) begin
    tdata_q <= tdata_d;
  end

  assign tx_tvalid = tvalid_q;
  assign tx_tlast  = tlast_q;
  assign tx_tid    = tid_q;
  assign tx_tdata  = tdata_q;

endmodule

// File: tb/tb_logic_basic_queue_arbiter.sv
// Scoreboard bench for logic_basic_queue_arbiter with three 8-bit inputs.
module tb_logic_basic_queue_arbiter;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int IW = 2;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          l;
  } src_t;

  typedef struct {
    logic [IW-1:0] tid;
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [N-1:0]  rx_tvalid;
  logic [N-1:0]  rx_tready;
  logic [N-1:0]  rx_tlast;
  logic [DW-1:0] rx_tdata [N];
  logic          tx_tready;
  logic          tx_tvalid;
  logic          tx_tlast;
  logic [IW-1:0] tx_tid;
  logic [DW-1:0] tx_tdata;

  src_t  src_q [N][$];
  exp_t  exp_q [$];
  int    obs_cyc [$];
  int    cyc;
  int    checks;
  int    passed;
  logic [N-1:0]  last_acc;
  logic          snap_v, snap_l;
  logic [DW-1:0] snap_d;

  always #5 aclk = ~aclk;

  logic_basic_queue_arbiter #(
    .INPUTS     (N),
    .DATA_WIDTH (DW)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .rx_tvalid (rx_tvalid),
    .rx_tready (rx_tready),
    .rx_tlast  (rx_tlast),
    .rx_tdata  (rx_tdata),
    .tx_tready (tx_tready),
    .tx_tvalid (tx_tvalid),
    .tx_tlast  (tx_tlast),
    .tx_tid    (tx_tid),
    .tx_tdata  (tx_tdata)
  );

  function automatic logic [DW-1:0] beat_data(input int src, input int pkt, input int b);
    return DW'(src * 64 + pkt * 8 + b);
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        rx_tvalid[i] = src_q[i][0].v;
        rx_tdata[i]  = src_q[i][0].d;
        rx_tlast[i]  = src_q[i][0].l;
      end else begin
        rx_tvalid[i] = 1'b0;
        rx_tdata[i]  = '0;
        rx_tlast[i]  = 1'b0;
      end
    end
  endtask

  task automatic push_src(input int i, input logic v, input logic [DW-1:0] d, input logic l);
    src_t s;
    s.v = v; s.d = d; s.l = l;
    src_q[i].push_back(s);
  endtask

  task automatic push_exp(input int tid, input logic [DW-1:0] d, input logic l);
    exp_t e;
    e.tid = IW'(tid); e.d = d; e.l = l;
    exp_q.push_back(e);
  endtask

  // one clock: sample at negedge, let the edge happen, then advance the sources
  task automatic step();
    exp_t e;
    @(negedge aclk);
    last_acc = rx_tvalid & rx_tready;
    snap_v = tx_tvalid; snap_d = tx_tdata; snap_l = tx_tlast;
    if (tx_tvalid && tx_tready) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_beat: got tid=%0d data=%h last=%b, expected no beat", tx_tid, tx_tdata, tx_tlast);
      end else begin
        e = exp_q.pop_front();
        obs_cyc.push_back(cyc);
        if (tx_tid !== e.tid || tx_tdata !== e.d || tx_tlast !== e.l)
          $display("FAIL beat: got tid=%0d data=%h last=%b, expected tid=%0d data=%h last=%b",
                   tx_tid, tx_tdata, tx_tlast, e.tid, e.d, e.l);
        else passed++;
      end
    end
    @(posedge aclk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++)
      if (src_q[i].size() > 0 && (last_acc[i] || !src_q[i][0].v)) void'(src_q[i].pop_front());
    drive();
  endtask

  task automatic run_until_empty(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL %s_timeout: got %0d beats still pending, expected 0", name, exp_q.size());
    else passed++;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    obs_cyc.delete();
    tx_tready = 1'b1;
    drive();
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    obs_cyc.delete();
    tx_tready = 1'b1;
    push_src(0, 1'b1, 8'h11, 1'b1);
    push_src(1, 1'b1, 8'h21, 1'b1);
    drive();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    checks++;
    if (tx_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b, expected 0", tx_tvalid); else passed++;
    checks++;
    if (tx_tlast !== 1'b0) $display("FAIL reset_tlast: got %b, expected 0", tx_tlast); else passed++;
    checks++;
    if (tx_tid !== 2'd0) $display("FAIL reset_tid: got %0d, expected 0", tx_tid); else passed++;
    checks++;
    if (rx_tready !== 3'b000) $display("FAIL reset_rx_tready: got %b, expected 000", rx_tready); else passed++;
    @(posedge aclk);
    #1 areset = 1'b0;
    cyc = 0;
    push_exp(0, 8'h11, 1'b1);
    push_exp(1, 8'h21, 1'b1);
    run_until_empty("reset", 20);
    checks++;
    if (obs_cyc.size() < 2 || obs_cyc[0] != 2 || obs_cyc[1] != 4)
      $display("FAIL reset_latency: got first=%0d second=%0d, expected 2 and 4",
               (obs_cyc.size() > 0) ? obs_cyc[0] : -1, (obs_cyc.size() > 1) ? obs_cyc[1] : -1);
    else passed++;
  endtask

  task automatic test_round_robin();
    int rem [N];
    int p, g, c;
    do_reset();
    for (int i = 0; i < N; i++) begin
      rem[i] = 3;
      for (int pk = 0; pk < 3; pk++) begin
        push_src(i, 1'b1, beat_data(i, pk, 0), 1'b0);
        push_src(i, 1'b1, beat_data(i, pk, 1), 1'b1);
      end
    end
    drive();
    p = 0;
    for (int k = 0; k < 3 * N; k++) begin
      g = -1;
      for (int j = 0; j < N; j++) begin
        c = (p + j) % N;
        if (g < 0 && rem[c] > 0) g = c;
      end
      push_exp(g, beat_data(g, 3 - rem[g], 0), 1'b0);
      push_exp(g, beat_data(g, 3 - rem[g], 1), 1'b1);
      rem[g]--;
`ifdef LOGIC_BASIC_QUEUE_ARBITER_FIXED_PRIORITY_EN
      p = 0;
`else
      p = (g + 1) % N;
`endif
    end
    run_until_empty("round_robin", 100);
    for (int k = 1; k < obs_cyc.size(); k++) begin
      checks++;
      if (obs_cyc[k] - obs_cyc[0] != (k / 2) * 3 + (k % 2))
        $display("FAIL rr_timing[%0d]: got offset %0d, expected %0d", k, obs_cyc[k] - obs_cyc[0], (k / 2) * 3 + (k % 2));
      else passed++;
    end
  endtask

  task automatic test_packet_lock();
    do_reset();
    push_src(0, 1'b1, 8'hA0, 1'b0);
    repeat (3) push_src(0, 1'b0, 8'h00, 1'b0);
    push_src(0, 1'b1, 8'hB0, 1'b1);
    push_src(1, 1'b1, 8'hC0, 1'b0);
    push_src(1, 1'b1, 8'hC1, 1'b1);
    drive();
    push_exp(0, 8'hA0, 1'b0);
    push_exp(0, 8'hB0, 1'b1);
    push_exp(1, 8'hC0, 1'b0);
    push_exp(1, 8'hC1, 1'b1);
    run_until_empty("packet_lock", 40);
  endtask

  task automatic test_backpressure();
    logic          ref_v, ref_l;
    logic [DW-1:0] ref_d;
    int            stall_acc;
    do_reset();
    for (int b = 0; b < 4; b++) begin
      push_src(0, 1'b1, DW'(8'h50 + b), (b == 3));
      push_exp(0, DW'(8'h50 + b), (b == 3));
    end
    drive();
    stall_acc = 0;
    ref_v = 1'b0; ref_l = 1'b0; ref_d = '0;
    for (int s = 0; s < 20; s++) begin
      tx_tready = !(s >= 3 && s < 8);
      step();
      if (s >= 3 && s < 8) begin
        for (int i = 0; i < N; i++) stall_acc += int'(last_acc[i]);
      end
      if (s == 3) begin
        ref_v = snap_v; ref_l = snap_l; ref_d = snap_d;
        checks++;
        if (snap_v !== 1'b1 || snap_d !== 8'h51)
          $display("FAIL bp_held_beat: got valid=%b data=%h, expected valid=1 data=51", snap_v, snap_d);
        else passed++;
      end else if (s > 3 && s < 8) begin
        checks++;
        if (snap_v !== ref_v || snap_d !== ref_d || snap_l !== ref_l)
          $display("FAIL bp_stable[%0d]: got v=%b d=%h l=%b, expected v=%b d=%h l=%b",
                   s, snap_v, snap_d, snap_l, ref_v, ref_d, ref_l);
        else passed++;
      end
    end
    tx_tready = 1'b1;
    checks++;
    if (stall_acc != 0) $display("FAIL bp_source_accepts: got %0d during stall, expected 0", stall_acc); else passed++;
    checks++;
    if (exp_q.size() != 0) $display("FAIL bp_drained: got %0d pending, expected 0", exp_q.size()); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_src(0, 1'b1, 8'h05, 1'b1);
    drive();
    push_exp(0, 8'h05, 1'b1);
    run_until_empty("mid_pre", 20);
    for (int b = 0; b < 4; b++) push_src(1, 1'b1, DW'(8'h30 + b), (b == 3));
    drive();
    push_exp(1, 8'h30, 1'b0);
    push_exp(1, 8'h31, 1'b0);
    run_until_empty("mid_pkt", 20);
    checks++;
    if (tx_tvalid !== 1'b1 || tx_tdata !== 8'h32)
      $display("FAIL mid_pre_reset: got valid=%b data=%h, expected valid=1 data=32", tx_tvalid, tx_tdata);
    else passed++;
    #2 areset = 1'b1;
    #1;
    checks++;
    if (tx_tvalid !== 1'b0 || tx_tlast !== 1'b0 || tx_tid !== 2'd0 || rx_tready !== 3'b000)
      $display("FAIL mid_async_reset: got valid=%b last=%b tid=%0d ready=%b, expected 0 0 0 000",
               tx_tvalid, tx_tlast, tx_tid, rx_tready);
    else passed++;
    for (int i = 0; i < N; i++) src_q[i].delete();
    obs_cyc.delete();
    push_src(0, 1'b1, 8'h07, 1'b1);
    push_src(1, 1'b1, 8'h37, 1'b1);
    drive();
    push_exp(0, 8'h07, 1'b1);
    push_exp(1, 8'h37, 1'b1);
    @(posedge aclk);
    #1 areset = 1'b0;
    cyc = 0;
    run_until_empty("mid_post", 20);
    checks++;
    if (obs_cyc.size() < 1 || obs_cyc[0] != 2)
      $display("FAIL mid_post_latency: got %0d, expected 2", (obs_cyc.size() > 0) ? obs_cyc[0] : -1);
    else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    cyc = 0;
    tx_tready = 1'b1;
    drive();
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_reset_mid();
    repeat (5) step();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, expected earlier finish");
    $fatal(1);
  end

endmodule
